sys_reset_ctrl: RTL and testbench

//  Consumes the system PLL locked status and the raw board reset; produces staged, glitch-free

---
 rtl/reset_ctrl_pkg.sv | 17 +
 rtl/sys_reset_ctrl_cdc_sync2.sv | 24 ++
 rtl/sys_reset_ctrl.sv | 156 +++++++++++++++
 tb/tb_sys_reset_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_ctrl_pkg.sv
// Shared types for the system reset controller: FSM states and reset-cause codes.
package reset_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_HOLD      = 3'd1,
    ST_REL_DDR   = 3'd2,
    ST_REL_BUS   = 3'd3,
    ST_RUN       = 3'd4,
    ST_SW_HOLD   = 3'd5
  } rst_state_t;

  localparam logic [1:0] RST_CAUSE_POR  = 2'd0;
  localparam logic [1:0] RST_CAUSE_LOCK = 2'd1;
  localparam logic [1:0] RST_CAUSE_SW   = 2'd2;

endpackage

// File: rtl/sys_reset_ctrl_cdc_sync2.sv
// Two-flop synchroniser bringing an asynchronous level into the i_clk domain.
module cdc_sync2 (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/sys_reset_ctrl.sv
// Staged DDR -> bus -> CPU reset release after PLL lock qualification, with
// software reset of CPU+bus, lock-loss recovery and reset-cause recording.
module sys_reset_ctrl
  import reset_ctrl_pkg::*;
#(
  parameter int unsigned LOCK_FILTER = 16,
  parameter int unsigned HOLD_CYCLES = 64,
  parameter int unsigned STAGE_GAP   = 8,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_pll_locked,
  input  logic       i_sw_rst_req,
  output logic       o_ddr_rst,
  output logic       o_bus_rst,
  output logic       o_cpu_rst,
  output logic       o_ready,
  output logic [1:0] o_rst_cause,
  output logic [7:0] o_lock_lost_cnt
);

  localparam logic [CNT_W-1:0] LF_LAST = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] HC_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SG_LAST = CNT_W'(STAGE_GAP - 1);

  logic lk;

  cdc_sync2 u_lock_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_pll_locked),
    .o_q     (lk)
  );

  rst_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ddr_q, ddr_d;
  logic             bus_q, bus_d;
  logic             cpu_q, cpu_d;
  logic             ready_q, ready_d;
  logic [1:0]       cause_q, cause_d;
  logic [7:0]       lost_q, lost_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    ddr_d   = ddr_q;
    bus_d   = bus_q;
    cpu_d   = cpu_q;
    ready_d = ready_q;
    cause_d = cause_q;
    lost_d  = lost_q;

    // Lock loss overrides everything, including a same-cycle software request.
    if (state_q != ST_WAIT_LOCK && !lk) begin
      state_d = ST_WAIT_LOCK;
      cnt_d   = '0;
      ddr_d   = 1'b1;
      bus_d   = 1'b1;
      cpu_d   = 1'b1;
      ready_d = 1'b0;
      cause_d = RST_CAUSE_LOCK;
      lost_d  = (lost_q == 8'hFF) ? lost_q : lost_q + 8'd1;
    end else begin
      case (state_q)
        ST_WAIT_LOCK: begin
          if (!lk) begin
            cnt_d = '0;
          end else if (cnt_q == LF_LAST) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end
        end
        ST_HOLD: begin
          if (cnt_q == HC_LAST) begin
            state_d = ST_REL_DDR;
            cnt_d   = '0;
            ddr_d   = 1'b0;
          end
        end
        ST_REL_DDR: begin
          if (cnt_q == SG_LAST) begin
            state_d = ST_REL_BUS;
            cnt_d   = '0;
            bus_d   = 1'b0;
          end
        end
        ST_REL_BUS: begin
          if (cnt_q == SG_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            cpu_d   = 1'b0;
            ready_d = 1'b1;
          end
        end
        ST_RUN: begin
          cnt_d = cnt_q;
          if (i_sw_rst_req) begin
            state_d = ST_SW_HOLD;
            cnt_d   = '0;
            bus_d   = 1'b1;
            cpu_d   = 1'b1;
            ready_d = 1'b0;
            cause_d = RST_CAUSE_SW;
          end
        end
        ST_SW_HOLD: begin
          if (cnt_q == HC_LAST) begin
            state_d = ST_REL_BUS;
            cnt_d   = '0;
            bus_d   = 1'b0;
          end
        end
        default: begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
          ddr_d   = 1'b1;
          bus_d   = 1'b1;
          cpu_d   = 1'b1;
          ready_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_WAIT_LOCK;
      cnt_q   <= '0;
      ddr_q   <= 1'b1;
      bus_q   <= 1'b1;
      cpu_q   <= 1'b1;
      ready_q <= 1'b0;
      cause_q <= RST_CAUSE_POR;
      lost_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ddr_q   <= ddr_d;
      bus_q   <= bus_d;
      cpu_q   <= cpu_d;
      ready_q <= ready_d;
      cause_q <= cause_d;
      lost_q  <= lost_d;
    end
  end

  assign o_ddr_rst       = ddr_q;
  assign o_bus_rst       = bus_q;
  assign o_cpu_rst       = cpu_q;
  assign o_ready         = ready_q;
  assign o_rst_cause     = cause_q;
  assign o_lock_lost_cnt = lost_q;

endmodule

// File: tb/tb_sys_reset_ctrl.sv
// Bench for sys_reset_ctrl: timestamp-based reference model checked every cycle,
// plus directed scenarios with hand-computed release latencies.
module tb_sys_reset_ctrl;

  localparam int LF = 16;
  localparam int HC = 64;
  localparam int SG = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b1;
  logic       swreq = 1'b0;
  logic       ddr_rst, bus_rst, cpu_rst, ready;
  logic [1:0] cause;
  logic [7:0] lost_cnt;

  int tests = 0;
  int fails = 0;
  int ecnt  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) ecnt++;

  sys_reset_ctrl #(
    .LOCK_FILTER (LF),
    .HOLD_CYCLES (HC),
    .STAGE_GAP   (SG),
    .CNT_W       (8)
  ) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_pll_locked    (locked),
    .i_sw_rst_req    (swreq),
    .o_ddr_rst       (ddr_rst),
    .o_bus_rst       (bus_rst),
    .o_cpu_rst       (cpu_rst),
    .o_ready         (ready),
    .o_rst_cause     (cause),
    .o_lock_lost_cnt (lost_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outputs follow from cycles elapsed since the last
  // qualification (or software request) anchor.
  bit m_valid = 0;
  bit m_wait  = 1;
  bit m_sw    = 0;
  int m_run   = 0;
  int m_anchor = 0;
  int m_cause = 0;
  int m_lost  = 0;
  int mcyc    = 0;
  bit h0 = 0, h1 = 0;

  always @(posedge clk or posedge rst) begin
    bit lk;
    int el_prev;
    bit in_run;
    if (rst) begin
      m_valid = 1; m_wait = 1; m_sw = 0; m_run = 0; m_anchor = 0;
      m_cause = 0; m_lost = 0; mcyc = 0; h0 = 0; h1 = 0;
    end else begin
      el_prev = mcyc - m_anchor;
      in_run  = !m_wait && (el_prev >= (m_sw ? HC + SG : HC + 2 * SG));
      mcyc++;
      lk = h1; h1 = h0; h0 = locked;
      if (!m_wait && !lk) begin
        m_wait = 1; m_run = 0; m_cause = 1;
        if (m_lost < 255) m_lost++;
      end else if (m_wait) begin
        if (lk) begin
          m_run++;
          if (m_run == LF) begin
            m_wait = 0; m_sw = 0; m_anchor = mcyc;
          end
        end else begin
          m_run = 0;
        end
      end else if (in_run && swreq) begin
        m_sw = 1; m_anchor = mcyc; m_cause = 2;
      end
    end
  end

  always @(negedge clk) begin
    int  el;
    bit  e_ddr, e_bus, e_cpu;
    if (m_valid) begin
      el    = mcyc - m_anchor;
      e_ddr = m_wait ? 1'b1 : (m_sw ? 1'b0 : (el < HC));
      e_bus = m_wait ? 1'b1 : (m_sw ? (el < HC) : (el < HC + SG));
      e_cpu = m_wait ? 1'b1 : (m_sw ? (el < HC + SG) : (el < HC + 2 * SG));
      chk("model_ddr",   32'(ddr_rst),  32'(e_ddr));
      chk("model_bus",   32'(bus_rst),  32'(e_bus));
      chk("model_cpu",   32'(cpu_rst),  32'(e_cpu));
      chk("model_ready", 32'(ready),    32'(!e_cpu));
      chk("model_cause", 32'(cause),    32'(m_cause));
      chk("model_lost",  32'(lost_cnt), 32'(m_lost));
    end
  end

  function automatic logic sig(input int which);
    case (which)
      0:       return ddr_rst;
      1:       return bus_rst;
      default: return cpu_rst;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits (bounded) for a reset output to fall; checks edges elapsed since t0.
  task automatic wait_low(input int which, input int t0, input string name, input int exp);
    int n = 0;
    while (sig(which) !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(ecnt - t0), 32'(exp));
  endtask

  int t0;

  initial begin
    // 1: power-on with lock present from the start
    tick(3);
    chk("por_ddr", 32'(ddr_rst), 32'd1);
    chk("por_bus", 32'(bus_rst), 32'd1);
    chk("por_cpu", 32'(cpu_rst), 32'd1);
    chk("por_ready", 32'(ready), 32'd0);
    chk("por_cause", 32'(cause), 32'd0);
    chk("por_lost", 32'(lost_cnt), 32'd0);
    rst = 1'b0;
    t0 = ecnt;
    wait_low(0, t0, "t1_ddr_release", 82);
    wait_low(1, t0, "t1_bus_release", 90);
    wait_low(2, t0, "t1_cpu_release", 98);
    chk("t1_ready", 32'(ready), 32'd1);
    chk("t1_cause", 32'(cause), 32'd0);

    // 3: lock loss in RUN, then re-lock
    tick(5);
    locked = 1'b0;
    tick(2);
    chk("t3_ddr_pre", 32'(ddr_rst), 32'd0);
    tick(1);
    chk("t3_ddr_loss", 32'(ddr_rst), 32'd1);
    chk("t3_ready", 32'(ready), 32'd0);
    chk("t3_cause", 32'(cause), 32'd1);
    chk("t3_lost", 32'(lost_cnt), 32'd1);
    locked = 1'b1;
    t0 = ecnt;
    wait_low(0, t0, "t3_ddr_release", 82);
    wait_low(2, t0, "t3_cpu_release", 98);

    // 4: software reset in RUN
    tick(4);
    swreq = 1'b1;
    t0 = ecnt;
    tick(1);
    swreq = 1'b0;
    chk("t4_cpu", 32'(cpu_rst), 32'd1);
    chk("t4_bus", 32'(bus_rst), 32'd1);
    chk("t4_ddr", 32'(ddr_rst), 32'd0);
    chk("t4_cause", 32'(cause), 32'd2);
    wait_low(1, t0, "t4_bus_release", 65);
    wait_low(2, t0, "t4_cpu_release", 73);
    chk("t4_ready", 32'(ready), 32'd1);

    // 2: one-cycle lock glitch at filter count 10
    locked = 1'b0;
    tick(4);
    locked = 1'b1;
    t0 = ecnt;
    tick(10);
    locked = 1'b0;
    tick(1);
    locked = 1'b1;
    wait_low(0, t0, "t2_ddr_release", 93);
    wait_low(2, t0, "t2_cpu_release", 109);

    // 5: simultaneous lock loss and software request; request during HOLD
    tick(3);
    locked = 1'b0;
    tick(2);
    swreq = 1'b1;
    tick(1);
    swreq = 1'b0;
    chk("t5_ddr", 32'(ddr_rst), 32'd1);
    chk("t5_cause", 32'(cause), 32'd1);
    chk("t5_lost", 32'(lost_cnt), 32'd3);
    locked = 1'b1;
    t0 = ecnt;
    tick(40);
    swreq = 1'b1;
    tick(1);
    swreq = 1'b0;
    wait_low(0, t0, "t5_ddr_release", 82);
    chk("t5_cause_hold", 32'(cause), 32'd1);
    wait_low(2, t0, "t5_cpu_release", 98);

    // 6: async reset in REL_BUS, then saturate the lock-loss counter
    locked = 1'b0;
    tick(3);
    locked = 1'b1;
    t0 = ecnt;
    wait_low(1, t0, "t6_bus_release", 90);
    tick(3);
    chk("t6_pre_cpu", 32'(cpu_rst), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_ddr", 32'(ddr_rst), 32'd1);
    chk("t6_async_bus", 32'(bus_rst), 32'd1);
    chk("t6_async_cpu", 32'(cpu_rst), 32'd1);
    chk("t6_async_ready", 32'(ready), 32'd0);
    chk("t6_async_cause", 32'(cause), 32'd0);
    chk("t6_async_lost", 32'(lost_cnt), 32'd0);
    locked = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      locked = 1'b1;
      tick(20);
      locked = 1'b0;
      tick(4);
    end
    chk("t6_lost_sat", 32'(lost_cnt), 32'd255);
    chk("t6_cause", 32'(cause), 32'd1);
    chk("t6_ddr", 32'(ddr_rst), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
